// File: rtl/intersection_arbiter_pkg.sv
// Shared types and default timing for the intersection arbiter.
// All durations are counted in tick strobes, not clock cycles.
package intersection_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        ALLRED = 2'd3
    } state_t;

    localparam int DEF_N_APP       = 4;
    localparam int DEF_T_MIN_GREEN = 4;
    localparam int DEF_T_MAX_GREEN = 12;
    localparam int DEF_T_YELLOW    = 2;
    localparam int DEF_T_ALLRED    = 1;
    localparam int DEF_T_WALK      = 6;
    localparam int TIMER_W         = 8;

endpackage

// File: rtl/intersection_arbiter_rr_pick.sv
// Round-robin selector: first pending index after grant_idx, wrapping,
// so grant_idx itself is considered last.
module rr_pick #(
    parameter int N_APP = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_APP-1:0] pend,
    input  logic [IDX_W-1:0] grant_idx,
    output logic             valid,
    output logic [IDX_W-1:0] next_idx
);

    int               j;
    logic [IDX_W-1:0] idx;

    // Scan from farthest to nearest so the nearest pending index wins.
    always_comb begin
        valid    = 1'b0;
        next_idx = grant_idx;
        j        = 0;
        idx      = '0;
        for (int off = N_APP; off >= 1; off--) begin
            j = int'(grant_idx) + off;
            if (j >= N_APP) j = j - N_APP;
            idx = IDX_W'(j);
            if (pend[idx]) begin
                valid    = 1'b1;
                next_idx = idx;
            end
        end
    end

endmodule

// File: rtl/intersection_arbiter.sv
// Traffic-light arbiter for N_APP approaches sharing one intersection,
// with round-robin service, min/max green and pedestrian walk phases.
module intersection_arbiter
    import intersection_arbiter_pkg::*;
#(
    parameter int N_APP       = DEF_N_APP,
    parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
    parameter int T_MAX_GREEN = DEF_T_MAX_GREEN,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALLRED    = DEF_T_ALLRED,
    parameter int T_WALK      = DEF_T_WALK
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic [N_APP-1:0]         req,
    input  logic [N_APP-1:0]         ped_req,
    output logic [N_APP-1:0]         green,
    output logic [N_APP-1:0]         yellow,
    output logic [N_APP-1:0]         red,
    output logic [N_APP-1:0]         walk,
    output logic [$clog2(N_APP)-1:0] grant_idx,
    output logic                     busy
);

    localparam int IDX_W = $clog2(N_APP);
    localparam logic [TIMER_W:0]   MIN_C    = (TIMER_W+1)'(T_MIN_GREEN);
    localparam logic [TIMER_W:0]   MAX_C    = (TIMER_W+1)'(T_MAX_GREEN);
    localparam logic [TIMER_W:0]   YEL_C    = (TIMER_W+1)'(T_YELLOW);
    localparam logic [TIMER_W:0]   ALLRED_C = (TIMER_W+1)'(T_ALLRED);
    localparam logic [TIMER_W-1:0] WALK_C   = TIMER_W'(T_WALK);

    state_t             state, state_n;
    logic [IDX_W-1:0]   grant_q, grant_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [TIMER_W:0]   cnt1;
    logic               walk_en, walk_en_n;
    logic [N_APP-1:0]   ped_lat, clr_mask;
    logic [N_APP-1:0]   pend, others;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               green_exit;

    assign pend   = req | ped_lat;
    assign others = pend & ~(N_APP'(1) << grant_q);
    assign cnt1   = {1'b0, timer} + (TIMER_W+1)'(1);
    assign green_exit = tick && (|others) &&
                        ((cnt1 >= MAX_C) || ((cnt1 >= MIN_C) && !req[grant_q]));

    rr_pick #(.N_APP(N_APP), .IDX_W(IDX_W)) u_rr_pick (
        .pend      (pend),
        .grant_idx (grant_q),
        .valid     (pick_valid),
        .next_idx  (pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant_q <= IDX_W'(N_APP - 1);
            timer   <= '0;
            walk_en <= 1'b0;
            ped_lat <= '0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            timer   <= timer_n;
            walk_en <= walk_en_n;
            ped_lat <= (ped_lat & ~clr_mask) | ped_req;
        end
    end

    // Entering GREEN captures the walk request and clears that approach's latch.
    always_comb begin
        state_n   = state;
        grant_n   = grant_q;
        timer_n   = timer;
        walk_en_n = walk_en;
        clr_mask  = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n   = GREEN;
                    grant_n   = pick_idx;
                    timer_n   = '0;
                    walk_en_n = ped_lat[pick_idx];
                    clr_mask  = N_APP'(1) << pick_idx;
                end
            end
            GREEN: begin
                if (green_exit) begin
                    state_n = YELLOW;
                    timer_n = '0;
                end else if (tick && (cnt1 <= MAX_C)) begin
                    timer_n = cnt1[TIMER_W-1:0];
                end
            end
            YELLOW: begin
                if (tick) begin
                    if (cnt1 >= YEL_C) begin
                        state_n = ALLRED;
                        timer_n = '0;
                    end else begin
                        timer_n = cnt1[TIMER_W-1:0];
                    end
                end
            end
            ALLRED: begin
                if (tick) begin
                    if (cnt1 >= ALLRED_C) begin
                        timer_n   = '0;
                        walk_en_n = 1'b0;
                        if (pick_valid) begin
                            state_n   = GREEN;
                            grant_n   = pick_idx;
                            walk_en_n = ped_lat[pick_idx];
                            clr_mask  = N_APP'(1) << pick_idx;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        timer_n = cnt1[TIMER_W-1:0];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        green  = '0;
        yellow = '0;
        red    = '1;
        walk   = '0;
        case (state)
            GREEN: begin
                green[grant_q] = 1'b1;
                red[grant_q]   = 1'b0;
                if (walk_en && (timer < WALK_C)) walk[grant_q] = 1'b1;
            end
            YELLOW: begin
                yellow[grant_q] = 1'b1;
                red[grant_q]    = 1'b0;
            end
            default: ;
        endcase
    end

    assign grant_idx = grant_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_intersection_arbiter.sv
// Directed bench for intersection_arbiter: one task per scenario, with a
// per-cycle lamp-safety monitor running alongside.
module tb_intersection_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] req = 4'b0;
    logic [3:0] ped_req = 4'b0;
    logic [3:0] green, yellow, red, walk;
    logic [1:0] grant_idx;
    logic       busy;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    intersection_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .req       (req),
        .ped_req   (ped_req),
        .green     (green),
        .yellow    (yellow),
        .red       (red),
        .walk      (walk),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Every approach shows exactly one lamp, and at most one approach is non-red.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ((int'(green[i]) + int'(yellow[i]) + int'(red[i])) != 1) begin
                    failures++;
                    $display("[TB] FAIL lamp_onehot[%0d]: got g=%b y=%b r=%b want exactly one", i, green[i], yellow[i], red[i]);
                end
            end
            checks++;
            if ($countones(green | yellow) > 1) begin
                failures++;
                $display("[TB] FAIL single_nonred: got non-red=%b want at most one bit", green | yellow);
            end
        end
    end

    task automatic pulse_tick();
        repeat (3) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic pulse_ticks(input int n);
        for (int i = 0; i < n; i++) pulse_tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick = 1'b0;
        req = 4'b0;
        ped_req = 4'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if (red !== 4'b1111) begin failures++; $display("[TB] FAIL reset_red: got %b want 1111", red); end
        checks++;
        if ((green | yellow | walk) !== 4'b0000) begin failures++; $display("[TB] FAIL reset_lamps: got g=%b y=%b w=%b want 0", green, yellow, walk); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (grant_idx !== 2'd3) begin failures++; $display("[TB] FAIL reset_grant: got %0d want 3", grant_idx); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_no_req_busy: got %b want 0", busy); end
    endtask

    task automatic test_idle_to_green();
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (green !== 4'b0100) begin failures++; $display("[TB] FAIL idle_green: got %b want 0100", green); end
        checks++;
        if (grant_idx !== 2'd2) begin failures++; $display("[TB] FAIL idle_grant: got %0d want 2", grant_idx); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL idle_busy: got %b want 1", busy); end
        pulse_ticks(20);
        checks++;
        if (green !== 4'b0100 || yellow !== 4'b0000) begin failures++; $display("[TB] FAIL green_rest: got g=%b y=%b want g=0100 y=0000", green, yellow); end
    endtask

    task automatic test_max_green();
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (green !== 4'b0001) begin failures++; $display("[TB] FAIL max_entry: got %b want 0001", green); end
        pulse_ticks(2);
        req = 4'b0011;
        for (int k = 3; k <= 11; k++) begin
            pulse_tick();
            checks++;
            if (green !== 4'b0001) begin failures++; $display("[TB] FAIL max_hold count=%0d: got %b want 0001", k, green); end
        end
        pulse_tick();
        checks++;
        if (yellow !== 4'b0001 || green !== 4'b0000) begin failures++; $display("[TB] FAIL max_yellow: got g=%b y=%b want y=0001", green, yellow); end
        pulse_tick();
        checks++;
        if (yellow !== 4'b0001) begin failures++; $display("[TB] FAIL max_yellow2: got %b want 0001", yellow); end
        pulse_tick();
        checks++;
        if (red !== 4'b1111) begin failures++; $display("[TB] FAIL max_allred: got %b want 1111", red); end
        pulse_tick();
        checks++;
        if (green !== 4'b0010 || grant_idx !== 2'd1) begin failures++; $display("[TB] FAIL max_next: got g=%b idx=%0d want 0010 idx 1", green, grant_idx); end
    endtask

    task automatic test_min_green();
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        pulse_tick();
        req = 4'b1000;
        pulse_ticks(2);
        checks++;
        if (green !== 4'b0001) begin failures++; $display("[TB] FAIL min_hold: got %b want 0001", green); end
        pulse_tick();
        checks++;
        if (yellow !== 4'b0001) begin failures++; $display("[TB] FAIL min_yellow: got %b want 0001", yellow); end
        pulse_ticks(3);
        checks++;
        if (green !== 4'b1000 || grant_idx !== 2'd3) begin failures++; $display("[TB] FAIL min_next: got g=%b idx=%0d want 1000 idx 3", green, grant_idx); end
    endtask

    task automatic test_ped_walk();
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        ped_req = 4'b0010;
        @(negedge clk);
        ped_req = 4'b0000;
        req = 4'b0100;
        checks++;
        if (walk !== 4'b0000) begin failures++; $display("[TB] FAIL ped_no_walk_now: got %b want 0000", walk); end
        pulse_ticks(4);
        checks++;
        if (yellow !== 4'b0010) begin failures++; $display("[TB] FAIL ped_yellow1: got %b want 0010", yellow); end
        pulse_ticks(3);
        checks++;
        if (green !== 4'b0100 || walk !== 4'b0000) begin failures++; $display("[TB] FAIL ped_green2: got g=%b w=%b want g=0100 w=0000", green, walk); end
        req = 4'b0000;
        pulse_ticks(7);
        checks++;
        if (green !== 4'b0010 || walk !== 4'b0010) begin failures++; $display("[TB] FAIL ped_walk_start: got g=%b w=%b want g=0010 w=0010", green, walk); end
        for (int k = 1; k <= 5; k++) begin
            pulse_tick();
            checks++;
            if (walk !== 4'b0010) begin failures++; $display("[TB] FAIL ped_walk_hold tick=%0d: got %b want 0010", k, walk); end
        end
        pulse_tick();
        checks++;
        if (walk !== 4'b0000 || green !== 4'b0010) begin failures++; $display("[TB] FAIL ped_walk_end: got w=%b g=%b want w=0000 g=0010", walk, green); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_idx;
        do_reset();
        req = 4'b1111;
        @(negedge clk);
        checks++;
        if (grant_idx !== 2'd0 || green !== 4'b0001) begin failures++; $display("[TB] FAIL rr_first: got idx=%0d g=%b want idx 0 g=0001", grant_idx, green); end
        for (int k = 1; k <= 4; k++) begin
            pulse_ticks(15);
            exp_idx = 2'(k % 4);
            checks++;
            if (grant_idx !== exp_idx || green !== (4'b0001 << exp_idx)) begin
                failures++;
                $display("[TB] FAIL rr_step%0d: got idx=%0d g=%b want idx=%0d", k, grant_idx, green, exp_idx);
            end
        end
    endtask

    task automatic test_reset_mid_yellow();
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0010;
        pulse_ticks(4);
        checks++;
        if (yellow !== 4'b0001) begin failures++; $display("[TB] FAIL rstmid_pre_yellow: got %b want 0001", yellow); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (red !== 4'b1111 || yellow !== 4'b0000 || walk !== 4'b0000) begin failures++; $display("[TB] FAIL rstmid_lamps: got r=%b y=%b w=%b want r=1111", red, yellow, walk); end
        checks++;
        if (busy !== 1'b0 || grant_idx !== 2'd3) begin failures++; $display("[TB] FAIL rstmid_state: got busy=%b idx=%0d want 0 idx 3", busy, grant_idx); end
        rst = 1'b1;
        req = 4'b1000;
        @(negedge clk);
        checks++;
        if (green !== 4'b1000 || grant_idx !== 2'd3) begin failures++; $display("[TB] FAIL rstmid_after: got g=%b idx=%0d want 1000 idx 3", green, grant_idx); end
    endtask

    initial begin
        test_reset();
        test_idle_to_green();
        test_max_green();
        test_min_green();
        test_ped_walk();
        test_round_robin();
        test_reset_mid_yellow();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intersection_arbiter.md
INTERSECTION_ARBITER -- requirements
Module: intersection_arbiter

Interface
REQ-001 Parameter N_APP, default 4, number of approaches sharing the intersection.
REQ-002 Parameter T_MIN_GREEN, default 4, minimum green duration in ticks.
REQ-003 Parameter T_MAX_GREEN, default 12, maximum green duration in ticks when another approach is waiting.
REQ-004 Parameter T_YELLOW, default 2, yellow duration in ticks.
REQ-005 Parameter T_ALLRED, default 1, all-red clearance duration in ticks.
REQ-006 Parameter T_WALK, default 6, walk duration in ticks; must satisfy T_WALK <= T_MIN_GREEN + 2.
REQ-007 clk  input  1  clock.
REQ-008 rst  input  1  reset, asynchronous, active-low.
REQ-009 tick  input  1  one-cycle timing strobe; all durations count tick cycles only.
REQ-010 req  input  N_APP  level vehicle-detector request per approach.
REQ-011 ped_req  input  N_APP  pedestrian button, one-cycle pulse per approach.
REQ-012 green, yellow, red  output  N_APP each  lamp per approach.
REQ-013 walk  output  N_APP  pedestrian walk lamp per approach.
REQ-014 grant_idx  output  clog2(N_APP)  index of the approach currently owning the intersection.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, GREEN, YELLOW and ALLRED.
REQ-017 pend[i] SHALL be defined as req[i] OR ped_lat[i].
REQ-018 ped_lat[i] SHALL set on ped_req[i] and clear only on entry to GREEN for approach i; a press in the entry cycle SHALL remain set.
REQ-019 In IDLE, all lamps SHALL be red; when any pend bit is set, the FSM SHALL enter GREEN for the approach chosen by the round-robin pick on the next cycle, independent of tick.
REQ-020 Round-robin pick SHALL return the first set pend index strictly after grant_idx, wrapping modulo N_APP; grant_idx itself SHALL be the lowest priority.
REQ-021 In GREEN, only green[grant_idx] SHALL be high and all other approaches SHALL show red.
REQ-022 The green tick counter SHALL start at 0 on entry and increment on each tick, saturating at T_MAX_GREEN.
REQ-023 GREEN SHALL go to YELLOW on a tick when some other approach is pending and either the count reaches T_MAX_GREEN, or the count is at least T_MIN_GREEN and req[grant_idx] is low.
REQ-024 With no other approach pending, GREEN SHALL rest indefinitely.
REQ-025 walk[grant_idx] SHALL be high for the first T_WALK ticks of GREEN when ped_lat[grant_idx] was set at entry, and SHALL drop at the GREEN exit.
REQ-026 YELLOW SHALL last T_YELLOW ticks with only yellow[grant_idx] high, then go to ALLRED.
REQ-027 ALLRED SHALL last T_ALLRED ticks with all lamps red.
REQ-028 At ALLRED expiry, the FSM SHALL go to GREEN for the round-robin pick if any pend bit is set, otherwise to IDLE.
REQ-029 The ALLRED-expiry pick SHALL include grant_idx, at lowest priority.
REQ-030 Exactly one of green, yellow and red SHALL be high per approach in every cycle.
REQ-031 At most one approach SHALL be non-red at any time.
REQ-032 Requests arriving during YELLOW or ALLRED SHALL be held in pend and SHALL not shorten or extend those states.

Reset
REQ-033 On rst low, the block SHALL asynchronously force state IDLE, all red bits 1, green, yellow and walk 0, busy 0, timers 0, ped_lat 0, and grant_idx N_APP-1, so that approach 0 is first priority.
REQ-034 Reset mid-phase SHALL abandon the phase immediately, with no yellow.

Structure
REQ-035 A shared package SHALL hold the state enum and the default timing constants.
REQ-036 Round-robin selection SHALL be a sub-module rr_pick, taking pend and grant_idx and returning a valid flag and the next index.

Verification
REQ-037 Reset, then req=4'b0100 with tick every 4 cycles -> IDLE to GREEN for approach 2 one cycle later; green resting, busy=1.
REQ-038 Green on approach 0 with req[0] held and req[1] raised at count 2 -> YELLOW at count 12, 2 ticks yellow, 1 tick all-red, then green[1].
REQ-039 Green on approach 0, req[0] dropped at count 1 and req[3] high -> yellow starts on the tick where count reaches 4.
REQ-040 ped_req[1] pulse during GREEN of approach 1 -> no walk this phase; walk[1] high for 6 ticks at the next green[1].
REQ-041 req=4'b1111 held -> grants cycle 0,1,2,3,0; lamp one-hot and single-non-red assertions hold every cycle.
REQ-042 rst low during YELLOW -> same cycle all red, walk 0, busy 0; after release with req[3] high -> green[3].
